// File: rtl/cbus_pkg.sv
// Shared cbus definitions: FSM state encodings, command polarity and default bus widths.
// Used by both the initiator (cbus_mst_if) and the target (cbus_select_if) ends of the bus.
package cbus_pkg;

  localparam int CBUS_DW = 32;
  localparam int CBUS_AW = 16;

  localparam logic CBUS_CMD_WRITE = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // A slave signals completion with either handshake line, depending on the command.
  function automatic logic cbus_ack(input logic waccept, input logic rresp);
    return waccept | rresp;
  endfunction

endpackage

// File: rtl/cbus_req_fifo.sv
// Two-entry synchronous request FIFO with a registered occupancy count.
// The head entry is presented combinationally on rdata whenever the FIFO is non-empty.
module cbus_req_fifo #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         sreset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!sreset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/cbus_mst_if.sv
// cbus initiator: queues local register requests, issues them one at a time on cbus,
// returns read data or a timeout error, and enforces the slave's minimum idle gap.
module cbus_mst_if
  import cbus_pkg::*;
#(
  parameter int DW       = CBUS_DW,
  parameter int AW       = CBUS_AW,
  parameter int TIM_WID  = 10,
  parameter int TIMEOUT  = 300,
  parameter int MIN_IDLE = 3
) (
  input  logic          clk,
  input  logic          sreset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          cbus_mst_cfg_req,
  output logic          cbus_mst_cmd,
  output logic [AW-1:0] cbus_mst_address,
  output logic [DW-1:0] cbus_mst_wdata,
  input  logic          cbus_mst_waccept,
  input  logic          cbus_mst_rresp,
  input  logic [DW-1:0] cbus_mst_rdatap
);

  localparam int FW    = 1 + AW + DW;
  localparam int GAP_W = (MIN_IDLE > 1) ? $clog2(MIN_IDLE) : 1;

  logic [1:0]         state;
  logic [TIM_WID-1:0] timer;
  logic [GAP_W-1:0]   gap_cnt;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FW-1:0]      fifo_head;
  logic               ack;
  logic               timed_out;

  assign req_ready = ~fifo_full;
  assign fifo_push = req_valid & ~fifo_full;
  assign busy      = ~fifo_empty | (state != ST_IDLE);

  cbus_req_fifo #(
    .W (FW)
  ) u_req_fifo (
    .clk      (clk),
    .sreset_n (sreset_n),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wdata    ({req_write, req_addr, req_wdata}),
    .rdata    (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fifo_pop  = 1'b0;
    ack       = 1'b0;
    timed_out = 1'b0;
    if (state == ST_IDLE) begin
      fifo_pop = ~fifo_empty;
    end
    if (state == ST_REQ) begin
      ack       = cbus_ack(cbus_mst_waccept, cbus_mst_rresp);
      timed_out = (timer == TIM_WID'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!sreset_n) begin
      state            <= ST_IDLE;
      timer            <= '0;
      gap_cnt          <= '0;
      cbus_mst_cfg_req <= 1'b0;
      cbus_mst_cmd     <= 1'b0;
      cbus_mst_address <= '0;
      cbus_mst_wdata   <= '0;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_rdata        <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            {cbus_mst_cmd, cbus_mst_address, cbus_mst_wdata} <= fifo_head;
            cbus_mst_cfg_req <= 1'b1;
            timer            <= '0;
            state            <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack is checked first so a response on the final timeout cycle still completes cleanly.
          if (ack) begin
            cbus_mst_cfg_req <= 1'b0;
            rsp_valid        <= 1'b1;
            rsp_err          <= 1'b0;
            rsp_rdata        <= (cbus_mst_cmd == CBUS_CMD_WRITE) ? '0 : cbus_mst_rdatap;
            gap_cnt          <= '0;
            state            <= ST_GAP;
          end else if (timed_out) begin
            cbus_mst_cfg_req <= 1'b0;
            rsp_valid        <= 1'b1;
            rsp_err          <= 1'b1;
            rsp_rdata        <= '0;
            gap_cnt          <= '0;
            state            <= ST_GAP;
          end else begin
            timer <= timer + TIM_WID'(1);
          end
        end
        ST_GAP: begin
          // GAP plus the following IDLE cycle keep cfg_req low for MIN_IDLE+1 cycles.
          if (gap_cnt == GAP_W'(MIN_IDLE - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_mst_if.sv
// Self-checking bench for cbus_mst_if: behavioural cbus slave, bus/response monitor,
// and a spec-level reference model for response, timing and gap expectations.
module tb_cbus_mst_if;

  localparam int DW       = 32;
  localparam int AW       = 16;
  localparam int TIMEOUT  = 300;
  localparam int MIN_IDLE = 3;

  logic          clk = 1'b0;
  logic          sreset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          cfg_req;
  logic          cmd;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic          waccept = 1'b0;
  logic          rresp = 1'b0;
  logic [DW-1:0] rdatap = '0;

  cbus_mst_if #(
    .DW (DW), .AW (AW), .TIM_WID (10), .TIMEOUT (TIMEOUT), .MIN_IDLE (MIN_IDLE)
  ) dut (
    .clk              (clk),
    .sreset_n         (sreset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_err          (rsp_err),
    .rsp_rdata        (rsp_rdata),
    .busy             (busy),
    .cbus_mst_cfg_req (cfg_req),
    .cbus_mst_cmd     (cmd),
    .cbus_mst_address (address),
    .cbus_mst_wdata   (wdata),
    .cbus_mst_waccept (waccept),
    .cbus_mst_rresp   (rresp),
    .cbus_mst_rdatap  (rdatap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slave: acks 'delay' cycles after seeing cfg_req (delay < 0 never acks).
  typedef struct { int delay; logic [DW-1:0] rdata; } slv_t;
  slv_t slv_q[$];
  slv_t slv_cur = '{-1, '0};
  int   hi_cnt = 0;
  logic ack_now;

  always @(negedge clk) begin
    if (cfg_req) begin
      hi_cnt++;
      if (hi_cnt == 1) begin
        if (slv_q.size() > 0) slv_cur = slv_q.pop_front();
        else                  slv_cur = '{-1, '0};
      end
    end else begin
      hi_cnt = 0;
    end
    ack_now = cfg_req && (slv_cur.delay >= 0) && (hi_cnt > slv_cur.delay);
    waccept = ack_now && cmd;
    rresp   = ack_now && !cmd;
    rdatap  = rresp ? slv_cur.rdata : DW'($urandom());
  end

  // Monitor: records access starts, cfg_req drops and responses with their cycle numbers.
  typedef struct { logic [AW-1:0] addr; logic cmd; logic [DW-1:0] wdata; int rise; } acc_t;
  typedef struct { logic err; logic [DW-1:0] rdata; int at; } rsp_t;
  acc_t acc_q[$];
  int   fall_q[$];
  rsp_t rsp_q[$];
  int   unstable = 0;
  logic prev_req = 1'b0;
  logic [AW+DW:0] prev_bus = '0;
  acc_t acc_tmp;
  rsp_t rsp_tmp;

  always @(negedge clk) begin
    if (cfg_req && !prev_req) begin
      acc_tmp = '{address, cmd, wdata, cyc};
      acc_q.push_back(acc_tmp);
    end
    if (!cfg_req && prev_req) fall_q.push_back(cyc);
    if (cfg_req && prev_req && ({cmd, address, wdata} != prev_bus)) unstable++;
    if (rsp_valid) begin
      rsp_tmp = '{rsp_err, rsp_rdata, cyc};
      rsp_q.push_back(rsp_tmp);
    end
    prev_req = cfg_req;
    prev_bus = {cmd, address, wdata};
  end

  // Reference model: what a response and the access duration must be, from the bus rules.
  function automatic logic exp_err(input int delay);
    return (delay < 0) || (delay >= TIMEOUT);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic w, input int delay, input logic [DW-1:0] rd);
    return (exp_err(delay) || w) ? '0 : rd;
  endfunction

  function automatic int exp_high(input int delay);
    return exp_err(delay) ? TIMEOUT : delay + 1;
  endfunction

  task automatic clear_logs();
    acc_q.delete();
    fall_q.delete();
    rsp_q.delete();
  endtask

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int delay, input logic [DW-1:0] rd, output int acc_cyc);
    int   n = 0;
    slv_t s;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!req_ready) begin
      n_bad++;
      $display("FAIL push_ready: req_ready=%0b after %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
      acc_cyc   = -1;
      return;
    end
    s = '{delay, rd};
    slv_q.push_back(s);
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    int k = 0;
    while (rsp_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    ok = (rsp_q.size() >= n);
  endtask

  task automatic settle();
    repeat (MIN_IDLE + 3) @(negedge clk);
  endtask

  task automatic test_reset();
    sreset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cfg_req, cmd, rsp_valid, rsp_err, busy, req_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_ctrl: {req,cmd,vld,err,busy,rdy}=%b, required 000001",
               {cfg_req, cmd, rsp_valid, rsp_err, busy, req_ready});
    end
    n_cmp++;
    if ({address, wdata, rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required all 0", address, wdata, rsp_rdata);
    end
    sreset_n = 1'b1;
    @(negedge clk);
  endtask

  // One directed access; all expectations come from the reference model above.
  task automatic run_single(input string name, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int delay, input logic [DW-1:0] rd);
    int pc;
    bit ok;
    clear_logs();
    push(w, a, d, delay, rd, pc);
    wait_rsp(1, TIMEOUT + 50, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_rsp: no rsp_valid within budget, required one", name);
      return;
    end
    n_cmp++;
    if (acc_q.size() != 1 || fall_q.size() != 1) begin
      n_bad++;
      $display("FAIL %s_accesses: starts=%0d drops=%0d, required 1/1", name, acc_q.size(), fall_q.size());
      return;
    end
    n_cmp++;
    if ({acc_q[0].cmd, acc_q[0].addr, acc_q[0].wdata} !== {w, a, d}) begin
      n_bad++;
      $display("FAIL %s_bus: cmd=%0b addr=%h wdata=%h, required %0b %h %h",
               name, acc_q[0].cmd, acc_q[0].addr, acc_q[0].wdata, w, a, d);
    end
    n_cmp++;
    if (acc_q[0].rise - pc != 1) begin
      n_bad++;
      $display("FAIL %s_latency: cfg_req rose %0d cycles after push, required 1", name, acc_q[0].rise - pc);
    end
    n_cmp++;
    if (fall_q[0] - acc_q[0].rise != exp_high(delay)) begin
      n_bad++;
      $display("FAIL %s_high: cfg_req high %0d cycles, required %0d", name, fall_q[0] - acc_q[0].rise, exp_high(delay));
    end
    n_cmp++;
    if ({rsp_q[0].err, rsp_q[0].rdata} !== {exp_err(delay), exp_rdata(w, delay, rd)}) begin
      n_bad++;
      $display("FAIL %s_data: err=%0b rdata=%h, required err=%0b rdata=%h",
               name, rsp_q[0].err, rsp_q[0].rdata, exp_err(delay), exp_rdata(w, delay, rd));
    end
    n_cmp++;
    if (rsp_q[0].at != fall_q[0]) begin
      n_bad++;
      $display("FAIL %s_rsp_cycle: rsp_valid at %0d, required with cfg_req drop at %0d", name, rsp_q[0].at, fall_q[0]);
    end
    settle();
    n_cmp++;
    if (busy !== 1'b0 || rsp_q.size() != 1) begin
      n_bad++;
      $display("FAIL %s_idle: busy=%0b responses=%0d, required 0/1", name, busy, rsp_q.size());
    end
  endtask

  task automatic test_write();
    run_single("write", 1'b1, 16'h0012, 32'hA5A5_0001, 4, DW'($urandom()));
  endtask

  task automatic test_read();
    run_single("read", 1'b0, 16'h8004, DW'($urandom()), 2, 32'hDEAD_BEEF);
  endtask

  task automatic test_timeout();
    run_single("timeout", 1'b0, AW'($urandom()), DW'($urandom()), -1, DW'($urandom()));
  endtask

  task automatic test_ack_on_last_cycle();
    run_single("ack_last", 1'b0, AW'($urandom()), DW'($urandom()), TIMEOUT - 1, DW'($urandom()));
  endtask

  task automatic test_back_to_back();
    int pc[4];
    bit ok;
    clear_logs();
    for (int i = 0; i < 4; i++) push(1'b1, AW'(16'h0100 + i), DW'($urandom()), 2, '0, pc[i]);
    wait_rsp(4, 200, ok);
    n_cmp++;
    if (!ok || acc_q.size() != 4 || fall_q.size() != 4) begin
      n_bad++;
      $display("FAIL b2b_count: responses=%0d starts=%0d drops=%0d, required 4", rsp_q.size(), acc_q.size(), fall_q.size());
      return;
    end
    n_cmp++;
    if (pc[3] != acc_q[1].rise + 1) begin
      n_bad++;
      $display("FAIL b2b_stall: 4th push accepted at %0d, required %0d (edge after 2nd pop)", pc[3], acc_q[1].rise + 1);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (acc_q[i+1].rise - fall_q[i] != MIN_IDLE + 1) begin
        n_bad++;
        $display("FAIL b2b_gap[%0d]: cfg_req low %0d cycles, required %0d", i, acc_q[i+1].rise - fall_q[i], MIN_IDLE + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (acc_q[i].addr !== AW'(16'h0100 + i)) begin
        n_bad++;
        $display("FAIL b2b_order[%0d]: addr=%h, required %h", i, acc_q[i].addr, AW'(16'h0100 + i));
      end
    end
    settle();
  endtask

  task automatic test_reset_mid_req();
    int pc;
    clear_logs();
    push(1'b0, AW'($urandom()), '0, -1, '0, pc);
    push(1'b1, AW'($urandom()), DW'($urandom()), 1, '0, pc);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cfg_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre: cfg_req=%0b before reset, required 1", cfg_req);
    end
    sreset_n = 1'b0;
    @(negedge clk);
    sreset_n = 1'b1;
    slv_q.delete();
    n_cmp++;
    if ({cfg_req, busy, req_ready, rsp_valid} !== 4'b0010) begin
      n_bad++;
      $display("FAIL rstmid_state: {req,busy,rdy,vld}=%b, required 0010", {cfg_req, busy, req_ready, rsp_valid});
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rsp_q.size() != 0 || acc_q.size() != 1 || cfg_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_after: responses=%0d starts=%0d cfg_req=%0b, required 0/1/0",
               rsp_q.size(), acc_q.size(), cfg_req);
    end
  endtask

  task automatic test_random();
    localparam int N = 16;
    logic          w  [N];
    logic [AW-1:0] a  [N];
    logic [DW-1:0] d  [N];
    logic [DW-1:0] rd [N];
    int            dl [N];
    int            pc;
    bit            ok;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      w[i]  = 1'($urandom());
      a[i]  = AW'($urandom());
      d[i]  = DW'($urandom());
      rd[i] = DW'($urandom());
      dl[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 9));
      push(w[i], a[i], d[i], dl[i], rd[i], pc);
    end
    wait_rsp(N, N * (TIMEOUT + 20), ok);
    n_cmp++;
    if (!ok || acc_q.size() != N || fall_q.size() != N) begin
      n_bad++;
      $display("FAIL rnd_count: responses=%0d starts=%0d drops=%0d, required %0d", rsp_q.size(), acc_q.size(), fall_q.size(), N);
      return;
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if ({rsp_q[i].err, rsp_q[i].rdata} !== {exp_err(dl[i]), exp_rdata(w[i], dl[i], rd[i])}) begin
        n_bad++;
        $display("FAIL rnd_rsp[%0d]: err=%0b rdata=%h, required err=%0b rdata=%h",
                 i, rsp_q[i].err, rsp_q[i].rdata, exp_err(dl[i]), exp_rdata(w[i], dl[i], rd[i]));
      end
      n_cmp++;
      if ({acc_q[i].cmd, acc_q[i].addr, acc_q[i].wdata} !== {w[i], a[i], d[i]}) begin
        n_bad++;
        $display("FAIL rnd_bus[%0d]: cmd=%0b addr=%h wdata=%h, required %0b %h %h",
                 i, acc_q[i].cmd, acc_q[i].addr, acc_q[i].wdata, w[i], a[i], d[i]);
      end
      n_cmp++;
      if (fall_q[i] - acc_q[i].rise != exp_high(dl[i])) begin
        n_bad++;
        $display("FAIL rnd_high[%0d]: cfg_req high %0d cycles, required %0d", i, fall_q[i] - acc_q[i].rise, exp_high(dl[i]));
      end
      if (i > 0) begin
        n_cmp++;
        if (acc_q[i].rise - fall_q[i-1] < MIN_IDLE + 1) begin
          n_bad++;
          $display("FAIL rnd_gap[%0d]: cfg_req low %0d cycles, required at least %0d", i, acc_q[i].rise - fall_q[i-1], MIN_IDLE + 1);
        end
      end
    end
    n_cmp++;
    if (unstable != 0) begin
      n_bad++;
      $display("FAIL bus_stable: %0d cycles with cmd/address/wdata changing under cfg_req, required 0", unstable);
    end
    settle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_on_last_cycle();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
